// File: rtl/ysyx_24090013_irom_arb.sv
// ysyx_24090013_irom_arb: IF/LS arbiter and single-cycle sequencer for the shared instruction ROM.
// Define IROM_ARB_RR_EN for round-robin arbitration; otherwise IF has fixed priority over LS.
module ysyx_24090013_irom_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] ROM_BASE = 32'h8000_0000,
  parameter int ROM_WORDS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              if_rsp_ready,
  input  logic              ls_req_valid,
  input  logic [ADDR_W-1:0] ls_req_addr,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              ls_rsp_err,
  input  logic              ls_rsp_ready,
  output logic              rom_ren,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);
  // One extra bit so the end bound cannot wrap at the top of the address space
  localparam logic [ADDR_W:0] ROM_END = {1'b0, ROM_BASE} + (ADDR_W+1)'(4 * ROM_WORDS);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_nxt;
  logic last_grant;
  logic [DATA_W-1:0] rsp_data;
  logic rsp_err;
  logic [ADDR_W-1:0] addr_q, win_addr;
  logic grant, pick_ls, legal, rsp_take;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (grant ? RESP : IDLE) : (rsp_take ? IDLE : RESP);
  // last_grant doubles as the response owner: both are set on every accept
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_grant <= 1'b1;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      addr_q     <= '0;
    end else if (grant) begin
      last_grant <= pick_ls;
      rsp_data   <= legal ? rom_data : '0;
      rsp_err    <= ~legal;
      addr_q     <= win_addr;
    end
  always_comb begin
    grant = ~rst & (state == IDLE) & (if_req_valid | ls_req_valid);
`ifdef IROM_ARB_RR_EN
    pick_ls = ls_req_valid & (~if_req_valid | ~last_grant);
`else
    pick_ls = ls_req_valid & ~if_req_valid;
`endif
    win_addr = pick_ls ? ls_req_addr : if_req_addr;
    legal = ({1'b0, win_addr} >= {1'b0, ROM_BASE}) && ({1'b0, win_addr} < ROM_END) &&
            (win_addr[1:0] == 2'b00);
    if_req_ready = grant & ~pick_ls;
    ls_req_ready = grant & pick_ls;
    rom_ren = grant & legal;
    rom_addr = grant ? win_addr : addr_q;
    if_rsp_valid = (state == RESP) & ~last_grant;
    ls_rsp_valid = (state == RESP) & last_grant;
    rsp_take = last_grant ? ls_rsp_ready : if_rsp_ready;
    if_rsp_data = rsp_data;
    ls_rsp_data = rsp_data;
    if_rsp_err = rsp_err;
    ls_rsp_err = rsp_err;
  end
endmodule

// File: doc/ysyx_24090013_irom_arb.md
# ysyx_24090013_irom_arb

Two-port arbiter and sequencer for the shared instruction ROM. It sits between the core's instruction-fetch port (IF) and a secondary load/debug port (LS) and owns the ROM's read-enable and address lines. It grants one request at a time, performs a single-cycle ROM read and holds the registered response until the winner accepts it. Out-of-range or misaligned addresses are answered with an error response and do not touch the ROM.

## Interface
Parameters:
- ADDR_W, 32, address width (byte addresses)
- DATA_W, 32, ROM word width
- ROM_BASE, 32'h8000_0000, byte address of ROM word 0
- ROM_WORDS, 20, number of words in the ROM

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req_valid  in  1  IF request present
- if_req_addr  in  ADDR_W  IF byte address
- if_req_ready  out  1  IF request accepted this cycle
- if_rsp_valid  out  1  IF response held
- if_rsp_data  out  DATA_W  IF read data
- if_rsp_err  out  1  IF address fault
- if_rsp_ready  in  1  IF consumes response
- ls_req_valid, ls_req_addr, ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err, ls_rsp_ready: same as the IF set, for LS
- rom_ren  out  1  ROM read enable
- rom_addr  out  ADDR_W  ROM byte address
- rom_data  in  DATA_W  ROM read data, combinational from rom_addr

## Operation
- The FSM has two states: IDLE and RESP.
- IDLE: if any req_valid, pick a winner (see arbitration).
  - In the same cycle, the winner's req_ready=1 and rom_addr is set to the winner's address.
  - rom_ren=1 only if the address is legal.
  - At the clock edge, rom_data is registered into the response (data, err=0), owner=winner, and the FSM moves to RESP.
- Legal address: ROM_BASE ≤ addr < ROM_BASE+4·ROM_WORDS and addr[1:0]==0. Range comparison is unsigned, full ADDR_W.
- Illegal address: rom_ren=0, response data=0, err=1. The request is still accepted and the FSM still moves to RESP.
- RESP: the owner's rsp_valid=1, and data/err are held stable. Both req_ready=0.
  - When the owner's rsp_ready=1, at the edge rsp_valid drops and the FSM returns to IDLE.
  - The non-owner's rsp_valid is always 0.
- rom_addr when not granting: holds its last value. rom_ren=0 outside the IDLE grant cycle.
- Arbitration: see Configuration. last_grant is updated on every accept.

## Timing
- Reset values:
  - FSM=IDLE, last_grant=LS.
  - All rsp_valid=0, rsp_data=0, rsp_err=0.
  - rom_ren=0, rom_addr=0.
  - Both req_ready=0 until a valid request arrives.
- Request-to-response latency: 1 cycle. Accept at edge N; rsp_valid is high from cycle N+1.
- Minimum turnaround: 2 cycles per transaction. No new accept occurs in the cycle the response is consumed.
- req_ready is combinational from req_valid and state; no ready-before-valid dependency exists.
- A requester must hold req_addr stable while req_valid=1 until accepted.
- Simultaneous IF and LS valid in IDLE: exactly one is accepted. The loser's req_ready=0 and it stays pending.
- rsp_ready while not in RESP, or from the non-owner: ignored.
- rst asserted mid-transaction: the pending response is discarded immediately (asynchronous) and no response is ever produced for it. The first cycle after release behaves as IDLE.

## Configuration
- IROM_ARB_RR_EN defined: round-robin. On a simultaneous request, the port not equal to last_grant wins. Since last_grant resets to LS, IF wins the first contest.
- IROM_ARB_RR_EN undefined: fixed priority, IF always beats LS. last_grant is still maintained but not used for selection.

## Test plan
- Single IF read at 0x8000_0004 with ROM word 1 = 0xDEAD_BEEF, if_rsp_ready held 1 → rom_ren=1 in the accept cycle; next cycle if_rsp_valid=1, data=0xDEAD_BEEF, err=0; then back to IDLE.
- LS reads at 0x8000_0050 (one past the end) and at 0x8000_0002 (misaligned) → rom_ren stays 0; each gets ls_rsp_valid=1, err=1, data=0.
- IF and LS both valid continuously, rsp_ready=1, IROM_ARB_RR_EN defined → grant order is IF, LS, IF, LS; each grant is 2 cycles apart.
- The same stimulus with IROM_ARB_RR_EN undefined → IF granted every transaction; LS starves while IF stays valid.
- IF response held with if_rsp_ready=0 for 5 cycles while LS is valid → if_rsp_valid and its data stay stable; ls_req_ready=0 throughout; LS is accepted in the first IDLE cycle after IF consumes.
- rst pulsed while in RESP → outputs return to reset values immediately; no response emerges after release; the next request completes normally.
